// File: rtl/ctrl_registro.sv
// ctrl_registro: sequences a load-then-shift job onto the 4-bit universal shift register.
// Optional CTRL_DIR_EN adds the dir_cfg port; without it the shift direction is fixed left.
module ctrl_registro #(
    parameter int   WIDTH = 4,
    parameter int   CNT_W = 3,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dato,
    input  logic [CNT_W-1:0] cuenta,
`ifdef CTRL_DIR_EN
    input  logic             dir_cfg,
`endif
    output logic             ocupado,
    output logic             listo,
    output logic             enb,
    output logic             dir,
    output logic             s_in,
    output logic [1:0]       modo,
    output logic [WIDTH-1:0] d
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cuenta_sat;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dir_q, dir_d, dir_in;
`ifdef CTRL_DIR_EN
    assign dir_in = dir_cfg;
`else
    assign dir_in = 1'b0;
`endif
    assign cuenta_sat = (cuenta > MAX_CNT) ? MAX_CNT : cuenta;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            dir_q   <= dir_d;
        end
    end
    // The counter is loaded at acceptance, so LOAD only has to decide skip-or-shift.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                cnt_d   = cuenta_sat;
                d_d     = dato;
                dir_d   = dir_in;
            end
            LOAD:  state_d = (cnt_q == '0) ? DONE : SHIFT;
            SHIFT: begin
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        ocupado = state_q != IDLE;
        listo   = state_q == DONE;
        enb     = (state_q == LOAD) || (state_q == SHIFT);
        modo    = (state_q == SHIFT) ? 2'b00 : 2'b10;
        s_in    = FILL;
        d       = d_q;
        dir     = dir_q;
    end
endmodule

// File: tb/tb_ctrl_registro.sv
// tb_ctrl_registro: randomized scoreboard bench; a behavioural shift register tracks q from DUT pins.
module tb_ctrl_registro;
`ifdef CTRL_DIR_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif
    typedef struct {
        int         start_cyc;
        int         n;
        logic [3:0] dato;
        logic [3:0] q;
        logic       dir;
    } exp_t;

    logic       clk = 1'b0, reset, start, dir_cfg;
    logic [3:0] dato;
    logic [2:0] cuenta;
    logic       ocupado, listo, enb, dir, s_in;
    logic [1:0] modo;
    logic [3:0] d;
    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0, errors = 0, cyc = 0, shifts = 0, busy = 0;
    logic [3:0] q = 4'b0;

    ctrl_registro dut (
        .clk(clk), .reset(reset), .start(start), .dato(dato), .cuenta(cuenta),
`ifdef CTRL_DIR_EN
        .dir_cfg(dir_cfg),
`endif
        .ocupado(ocupado), .listo(listo), .enb(enb), .dir(dir), .s_in(s_in),
        .modo(modo), .d(d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] v, input int n, input logic right);
        return right ? 4'(v >> n) : 4'(v << n);
    endfunction

    // Registro stand-in plus scoreboard monitor; samples on the falling edge.
    always @(negedge clk) if (!reset) begin
        if (enb && modo == 2'b10) begin
            q = d;
            shifts = 0;
            busy = 0;
        end else if (enb && modo == 2'b00) begin
            q = dir ? {s_in, q[3:1]} : {q[2:0], s_in};
            shifts++;
        end
        if (ocupado) busy++;
        if (listo) begin
            if (exp_q.size() == 0) check("spurious_listo", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("latency", cyc - e.start_cyc, e.n + 2);
                check("shift_cycles", shifts, e.n);
                check("ocupado_cycles", busy, e.n + 2);
                check("q_final", q, e.q);
                check("d_held", d, e.dato);
                check("dir", dir, e.dir);
                check("enb_in_done", enb, 0);
            end
        end
    end

    task automatic wait_idle();
        int w = 0;
        while (ocupado && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        if (ocupado) check("idle_timeout", 1, 0);
    endtask

    task automatic run_job(input logic [3:0] v, input logic [2:0] c, input logic r, input bit poke);
        int n, k, p;
        wait_idle();
        n = (c > 3'd4) ? 4 : int'(c);
        dato = v; cuenta = c; dir_cfg = r; start = 1'b1;
        k = cyc;
        exp_q.push_back('{k, n, v, model(v, n, r & DIR_EN), r & DIR_EN});
        @(posedge clk); #1;
        start = 1'b0;
        dato = 4'($urandom); cuenta = 3'($urandom); dir_cfg = 1'($urandom);
        if (poke) begin
            p = $urandom_range(0, n + 1);
            repeat (p) begin @(posedge clk); #1; end
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        int w;
        logic [3:0] qs;
        reset = 1'b1; start = 1'b0; dato = '0; cuenta = '0; dir_cfg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ocupado", ocupado, 0);
        check("rst_listo", listo, 0);
        check("rst_enb", enb, 0);
        check("rst_modo", modo, 2'b10);
        check("rst_d", d, 0);
        check("rst_dir", dir, 0);
        check("rst_s_in", s_in, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_job(4'b1011, 3'd0, 1'b0, 1'b0);
        run_job(4'b1111, 3'd4, 1'b0, 1'b0);
        run_job(4'b1010, 3'd7, 1'b0, 1'b1);
        run_job(4'b1000, 3'd2, 1'b1, 1'b0);
        wait_idle();
        dato = 4'b1111; cuenta = 3'd4; dir_cfg = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        qs = q;
        #2 reset = 1'b1;
        #1;
        check("async_rst_enb", enb, 0);
        check("async_rst_ocupado", ocupado, 0);
        check("async_rst_listo", listo, 0);
        check("async_rst_modo", modo, 2'b10);
        check("async_rst_d", d, 0);
        repeat (2) begin @(posedge clk); #1; end
        check("q_frozen", q, qs);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++)
            run_job(4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("queue_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", ocupado, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
